// File: rtl/display_pkg.sv
// Shared types and constants for the display adapter host write path.
package display_pkg;

    localparam int ADDR_W_DFLT = 20;
    localparam int PD_W_DFLT   = 10;
    localparam int DATA_W_DFLT = 32;
    localparam int PIX_W_DFLT  = 24;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        WAIT0 = 2'd2,
        WAIT1 = 2'd3
    } wr_state_t;

    // Buffer a state is working towards: 0 = Buf0, 1 = Buf1.
    function automatic logic state_target(input wr_state_t s);
        return (s == FILL1) || (s == WAIT1);
    endfunction

    function automatic logic state_fills(input wr_state_t s);
        return (s == FILL0) || (s == FILL1);
    endfunction

endpackage

// File: rtl/display_buf_writer_wr_addr_counter.sv
// Sequential write address and latched frame size for the buffer being filled.
// While the address sits at 0 (or a restart is requested) the size tracks its input live.
module wr_addr_counter
    import display_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    input  logic              load_size,
    input  logic [ADDR_W-1:0] size_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              zero_size
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] n_d;
    logic              start_s;

    // Effective address/size for this cycle; a restart behaves as address 0 with a fresh size.
    always_comb begin
        start_s   = load_size || (addr_q == {ADDR_W{1'b0}});
        addr      = start_s ? {ADDR_W{1'b0}} : addr_q;
        n_d       = start_s ? size_in : n_q;
        zero_size = (n_d == {ADDR_W{1'b0}});
        last      = !zero_size && (addr == (n_d - {{(ADDR_W-1){1'b0}}, 1'b1}));
        if (clr) begin
            addr_d = {ADDR_W{1'b0}};
        end else if (inc) begin
            addr_d = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr;
        end
    end

    // Address and size registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= {ADDR_W{1'b0}};
            n_q    <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
            n_q    <= n_d;
        end
    end

endmodule

// File: rtl/display_buf_writer.sv
// Host-side ping-pong writer: accepts pixel words and fills Buf0/Buf1 frame by frame,
// tracking full flags that the display read side releases with RdDone pulses.
module display_buf_writer
    import display_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int PIX_W  = PIX_W_DFLT,
    parameter int PD_W   = PD_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] WData,
    input  logic              CSDisplay,
    input  logic              WValid,
    input  logic              WSof,
    output logic              WReady,
    input  logic [PD_W-1:0]   AIPOut_PD,
    input  logic [PD_W-1:0]   AILOut_PD,
    input  logic              RdDone0,
    input  logic              RdDone1,
    output logic              WE0,
    output logic              WE1,
    output logic [ADDR_W-1:0] WAddr,
    output logic [PIX_W-1:0]  WPixel,
    output logic              Buf0Full,
    output logic              Buf1Full,
    output logic              FillBuf,
    output logic              SizeErr
);

    wr_state_t         state_q, state_d;
    logic              full0_q, full0_d;
    logic              full1_q, full1_d;
    logic              wready_q, wready_d;
    logic              we0_q, we0_d;
    logic              we1_q, we1_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [PIX_W-1:0]  wpixel_q, wpixel_d;
    logic              fill_buf_q, fill_buf_d;
    logic              size_err_q, size_err_d;

    logic              accept_s;
    logic              restart_s;
    logic              write_s;
    logic              tgt_s;
    logic              frame_done_s;
    logic [ADDR_W-1:0] size_s;
    logic [ADDR_W-1:0] addr_s;
    logic              last_s;
    logic              zero_s;
    logic              wdata_unused_s;

    assign wdata_unused_s = ^WData[DATA_W-1:R_MSB+1];

    wr_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk       (clk),
        .reset     (reset),
        .inc       (write_s && !last_s),
        .clr       (frame_done_s),
        .load_size (restart_s),
        .size_in   (size_s),
        .addr      (addr_s),
        .last      (last_s),
        .zero_size (zero_s)
    );

    // Handshake, full-flag update, next state and next registered outputs.
    always_comb begin
        size_s       = ADDR_W'(AIPOut_PD) * ADDR_W'(AILOut_PD);
        accept_s     = CSDisplay && WValid && wready_q;
        restart_s    = accept_s && WSof;
        write_s      = accept_s && !zero_s;
        frame_done_s = write_s && last_s;
        tgt_s        = state_target(state_q);

        // Writing a buffer implies it is empty, so release and completion never collide.
        full0_d = (full0_q && !RdDone0) || (frame_done_s && !tgt_s);
        full1_d = (full1_q && !RdDone1) || (frame_done_s && tgt_s);

        state_d = state_q;
        case (state_q)
            FILL0: begin
                if (frame_done_s) begin
                    state_d = (full1_q && !RdDone1) ? WAIT1 : FILL1;
                end else begin
                    state_d = FILL0;
                end
            end
            FILL1: begin
                if (frame_done_s) begin
                    state_d = (full0_q && !RdDone0) ? WAIT0 : FILL0;
                end else begin
                    state_d = FILL1;
                end
            end
            WAIT0: begin
                state_d = full0_q ? WAIT0 : FILL0;
            end
            WAIT1: begin
                state_d = full1_q ? WAIT1 : FILL1;
            end
            default: begin
                state_d = FILL0;
            end
        endcase

        we0_d      = write_s && !tgt_s;
        we1_d      = write_s && tgt_s;
        waddr_d    = write_s ? addr_s : waddr_q;
        wpixel_d   = write_s ? {WData[R_MSB:R_LSB], WData[G_MSB:G_LSB], WData[B_MSB:B_LSB]}
                             : wpixel_q;
        fill_buf_d = state_target(state_d);
        wready_d   = state_fills(state_d) && !(fill_buf_d ? full1_d : full0_d);
        size_err_d = zero_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL0;
            full0_q    <= 1'b0;
            full1_q    <= 1'b0;
            wready_q   <= 1'b1;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            waddr_q    <= {ADDR_W{1'b0}};
            wpixel_q   <= {PIX_W{1'b0}};
            fill_buf_q <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full0_q    <= full0_d;
            full1_q    <= full1_d;
            wready_q   <= wready_d;
            we0_q      <= we0_d;
            we1_q      <= we1_d;
            waddr_q    <= waddr_d;
            wpixel_q   <= wpixel_d;
            fill_buf_q <= fill_buf_d;
            size_err_q <= size_err_d;
        end
    end

    assign WReady   = wready_q;
    assign WE0      = we0_q;
    assign WE1      = we1_q;
    assign WAddr    = waddr_q;
    assign WPixel   = wpixel_q;
    assign Buf0Full = full0_q;
    assign Buf1Full = full1_q;
    assign FillBuf  = fill_buf_q;
    assign SizeErr  = size_err_q;

endmodule

// File: tb/tb_display_buf_writer.sv
// Directed bench for display_buf_writer: ping-pong fill, release, CS gating, SOF restart,
// zero frame size, mid-fill size change and simultaneous release/completion.
module tb_display_buf_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] WData;
    logic        CSDisplay;
    logic        WValid;
    logic        WSof;
    logic        WReady;
    logic [9:0]  AIPOut_PD;
    logic [9:0]  AILOut_PD;
    logic        RdDone0;
    logic        RdDone1;
    logic        WE0;
    logic        WE1;
    logic [19:0] WAddr;
    logic [23:0] WPixel;
    logic        Buf0Full;
    logic        Buf1Full;
    logic        FillBuf;
    logic        SizeErr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    display_buf_writer dut (
        .clk       (clk),
        .reset     (reset),
        .WData     (WData),
        .CSDisplay (CSDisplay),
        .WValid    (WValid),
        .WSof      (WSof),
        .WReady    (WReady),
        .AIPOut_PD (AIPOut_PD),
        .AILOut_PD (AILOut_PD),
        .RdDone0   (RdDone0),
        .RdDone1   (RdDone1),
        .WE0       (WE0),
        .WE1       (WE1),
        .WAddr     (WAddr),
        .WPixel    (WPixel),
        .Buf0Full  (Buf0Full),
        .Buf1Full  (Buf1Full),
        .FillBuf   (FillBuf),
        .SizeErr   (SizeErr)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic sof);
        WData     = d;
        WSof      = sof;
        CSDisplay = 1'b1;
        WValid    = 1'b1;
        tick();
        CSDisplay = 1'b0;
        WValid    = 1'b0;
        WSof      = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic b, input int a, input logic [23:0] pix);
        chk1({tag, ".WE0"}, WE0, !b);
        chk1({tag, ".WE1"}, WE1, b);
        chkw({tag, ".WAddr"}, 32'(WAddr), 32'(a));
        chkw({tag, ".WPixel"}, 32'(WPixel), 32'(pix));
    endtask

    task automatic check_no_write(input string tag);
        chk1({tag, ".WE0"}, WE0, 1'b0);
        chk1({tag, ".WE1"}, WE1, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        WData     = 32'h0;
        CSDisplay = 1'b0;
        WValid    = 1'b0;
        WSof      = 1'b0;
        AIPOut_PD = 10'd4;
        AILOut_PD = 10'd2;
        RdDone0   = 1'b0;
        RdDone1   = 1'b0;
        tick();
        tick();
        chk1("rst.WReady", WReady, 1'b1);
        check_no_write("rst");
        chk1("rst.Buf0Full", Buf0Full, 1'b0);
        chk1("rst.Buf1Full", Buf1Full, 1'b0);
        chk1("rst.FillBuf", FillBuf, 1'b0);
        chk1("rst.SizeErr", SizeErr, 1'b0);
        chkw("rst.WAddr", 32'(WAddr), 32'h0);
        chkw("rst.WPixel", 32'(WPixel), 32'h0);
        reset = 1'b1;
        tick();
        tick();

        // 1: fill Buf0, upper WData bits must be dropped
        for (int i = 0; i < 8; i++) begin
            put({8'hA5, 24'(i + 1)}, 1'b0);
            check_write($sformatf("t1.w%0d", i), 1'b0, i, 24'(i + 1));
            chk1($sformatf("t1.full0_%0d", i), Buf0Full, (i == 7));
        end
        chk1("t1.FillBuf", FillBuf, 1'b1);
        chk1("t1.WReady", WReady, 1'b1);

        // 2: fill Buf1 -> WAIT0, then release Buf0
        for (int i = 0; i < 8; i++) begin
            put(32'h10 + 32'(i), 1'b0);
            check_write($sformatf("t2.w%0d", i), 1'b1, i, 24'h10 + 24'(i));
            chk1($sformatf("t2.full1_%0d", i), Buf1Full, (i == 7));
        end
        chk1("t2.wait.WReady", WReady, 1'b0);
        chk1("t2.wait.FillBuf", FillBuf, 1'b0);
        put(32'h99, 1'b0);
        check_no_write("t2.wait.offer");
        chk1("t2.wait.WReady2", WReady, 1'b0);
        RdDone0 = 1'b1;
        tick();
        RdDone0 = 1'b0;
        chk1("t2.rel.Buf0Full", Buf0Full, 1'b0);
        chk1("t2.rel.Buf1Full", Buf1Full, 1'b1);
        chk1("t2.rel.WReady", WReady, 1'b0);
        tick();
        chk1("t2.fill.WReady", WReady, 1'b1);
        put(32'h55, 1'b0);
        check_write("t2.first", 1'b0, 0, 24'h55);
        put(32'h56, 1'b0);
        check_write("t2.second", 1'b0, 1, 24'h56);

        // 3: chip select low blocks writes, address holds
        WData     = 32'h77;
        CSDisplay = 1'b0;
        WValid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_no_write($sformatf("t3.cs%0d", i));
        end
        WValid = 1'b0;
        put(32'h57, 1'b0);
        check_write("t3.resume", 1'b0, 2, 24'h57);

        // 4: SOF restarts at address 0; 6: last word with RdDone1 goes straight to FILL1
        put(32'h00ABCDEF, 1'b1);
        check_write("t4.sof", 1'b0, 0, 24'hABCDEF);
        chk1("t4.sof.Buf0Full", Buf0Full, 1'b0);
        chk1("t4.sof.Buf1Full", Buf1Full, 1'b1);
        for (int i = 1; i < 8; i++) begin
            if (i == 7) begin
                RdDone1 = 1'b1;
            end
            put(32'h20 + 32'(i), 1'b0);
            RdDone1 = 1'b0;
            check_write($sformatf("t4.w%0d", i), 1'b0, i, 24'h20 + 24'(i));
        end
        chk1("t6.Buf0Full", Buf0Full, 1'b1);
        chk1("t6.Buf1Full", Buf1Full, 1'b0);
        chk1("t6.FillBuf", FillBuf, 1'b1);
        chk1("t6.WReady", WReady, 1'b1);
        put(32'h31, 1'b0);
        check_write("t6.next", 1'b1, 0, 24'h31);

        // 5: reset mid-fill with zero frame size
        AIPOut_PD = 10'd0;
        reset     = 1'b0;
        tick();
        reset = 1'b1;
        chk1("t5.rst.Buf0Full", Buf0Full, 1'b0);
        chk1("t5.rst.Buf1Full", Buf1Full, 1'b0);
        chk1("t5.rst.FillBuf", FillBuf, 1'b0);
        tick();
        tick();
        chk1("t5.SizeErr", SizeErr, 1'b1);
        chk1("t5.WReady", WReady, 1'b1);
        put(32'h41, 1'b0);
        check_no_write("t5.z0");
        put(32'h42, 1'b0);
        check_no_write("t5.z1");
        chk1("t5.SizeErr2", SizeErr, 1'b1);
        AIPOut_PD = 10'd4;
        tick();
        chk1("t5.SizeOk", SizeErr, 1'b0);
        put(32'h77, 1'b0);
        check_write("t5.first", 1'b0, 0, 24'h77);

        // size change mid-fill is ignored: frame still ends at address 7
        AIPOut_PD = 10'd8;
        for (int i = 1; i < 8; i++) begin
            put(32'h80 + 32'(i), 1'b0);
            check_write($sformatf("t5.w%0d", i), 1'b0, i, 24'h80 + 24'(i));
            chk1($sformatf("t5.full0_%0d", i), Buf0Full, (i == 7));
        end
        chk1("t5.FillBuf", FillBuf, 1'b1);
        chk1("t5.SizeErr3", SizeErr, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
